// File: rtl/move_ctrl_pkg.sv
// Shared types and opcode constants for the move-instruction control sequencer.
package move_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_MTHI = 5'b11010;
  localparam logic [4:0] OP_MTLO = 5'b11011;

  typedef struct packed {
    logic gra;
    logic rin;
    logic rout;
    logic hio;
    logic loo;
    logic hii;
    logic loi;
    logic ipo;
    logic opi;
  } exec_strb_t;

endpackage

// File: rtl/move_ctrl_decode.sv
// Combinational opcode decode into the execute-step strobe set plus a valid flag.
module move_ctrl_decode
  import move_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output exec_strb_t          strb_o,
  output logic                valid_o
);

  always_comb begin
    strb_o  = '0;
    valid_o = 1'b1;
    case (opcode_i)
      OPCODE_W'(OP_MFHI): begin strb_o.hio = 1'b1; strb_o.gra = 1'b1; strb_o.rin  = 1'b1; end
      OPCODE_W'(OP_MFLO): begin strb_o.loo = 1'b1; strb_o.gra = 1'b1; strb_o.rin  = 1'b1; end
      OPCODE_W'(OP_MTHI): begin strb_o.gra = 1'b1; strb_o.rout = 1'b1; strb_o.hii = 1'b1; end
      OPCODE_W'(OP_MTLO): begin strb_o.gra = 1'b1; strb_o.rout = 1'b1; strb_o.loi = 1'b1; end
      OPCODE_W'(OP_IN):   begin strb_o.ipo = 1'b1; strb_o.gra = 1'b1; strb_o.rin  = 1'b1; end
      OPCODE_W'(OP_OUT):  begin strb_o.gra = 1'b1; strb_o.rout = 1'b1; strb_o.opi = 1'b1; end
      default:            valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/move_ctrl_seq.sv
// Control-step sequencer (T0-T3) for mfhi/mflo/mthi/mtlo/in/out.
// Optional memory-wait timeout is compiled in with MOVE_CTRL_TIMEOUT_EN.
module move_ctrl_seq
  import move_ctrl_pkg::*;
#(
  parameter int OPCODE_W       = 5,
  parameter bit AUTO_RUN       = 1'b0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic                mem_ready,
  output logic                pco,
  output logic                mari,
  output logic                pc_inc,
  output logic                mem_read,
  output logic                mdri,
  output logic                mdro,
  output logic                iri,
  output logic                gra,
  output logic                rin,
  output logic                rout,
  output logic                hio,
  output logic                loo,
  output logic                hii,
  output logic                loi,
  output logic                ipo,
  output logic                opi,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                fault
);

  state_e     state_q, state_d;
  exec_strb_t exec_strb;
  logic       dec_valid;
  logic       tmo_hit;
  logic       err_flt_q;

  move_ctrl_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode_i (ir_opcode),
    .strb_o   (exec_strb),
    .valid_o  (dec_valid)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

`ifdef MOVE_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_flt_d;

  // Counter holds the number of T1 cycles already spent; it is zero on T1 entry.
  assign tmo_cnt_d = (state_q == S_T1) ? tmo_cnt_q + 1'b1 : '0;
  assign tmo_hit   = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_flt_d = (state_q == S_T1) && !mem_ready && tmo_hit;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      tmo_cnt_q <= '0;
      err_flt_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_flt_q <= err_flt_d;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign err_flt_q = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pco      = 1'b0;
    mari     = 1'b0;
    pc_inc   = 1'b0;
    mem_read = 1'b0;
    mdri     = 1'b0;
    mdro     = 1'b0;
    iri      = 1'b0;
    {gra, rin, rout, hio, loo, hii, loi, ipo, opi} = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    fault    = 1'b0;
    busy     = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        pco     = 1'b1;
        mari    = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        mem_read = 1'b1;
        mdri     = mem_ready;
        if (mem_ready)    state_d = S_T2;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_T2: begin
        mdro    = 1'b1;
        iri     = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        {gra, rin, rout, hio, loo, hii, loi, ipo, opi} = exec_strb;
        state_d = dec_valid ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = AUTO_RUN ? S_T0 : S_IDLE;
      end
      S_ERR: begin
        illegal = !err_flt_q;
        fault   = err_flt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_ctrl_seq.sv
// Bench for move_ctrl_seq: timestamp-based reference model plus directed literal checks.
module tb_move_ctrl_seq;

  localparam logic [19:0] PCO  = 20'h80000, MARI = 20'h40000, PCI  = 20'h20000;
  localparam logic [19:0] MRD  = 20'h10000, MDRI = 20'h08000, MDRO = 20'h04000;
  localparam logic [19:0] IRI  = 20'h02000, GRA  = 20'h01000, RIN  = 20'h00800;
  localparam logic [19:0] ROUT = 20'h00400, HIO  = 20'h00200, LOO  = 20'h00100;
  localparam logic [19:0] HII  = 20'h00080, LOI  = 20'h00040, IPO  = 20'h00020;
  localparam logic [19:0] OPI  = 20'h00010, BSY  = 20'h00008, DON  = 20'h00004;
  localparam logic [19:0] ILL  = 20'h00002, FLT  = 20'h00001;
  localparam logic [19:0] T0V  = PCO | MARI | PCI | BSY;
  localparam int TMO = 16;
`ifdef MOVE_CTRL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic clear;
  logic start_a [2];
  logic mr_a    [2];
  logic [4:0] opc_a [2];
  logic [1:0] pco, mari, pc_inc, mem_read, mdri, mdro, iri, gra, rin, rout;
  logic [1:0] hio, loo, hii, loi, ipo, opi, busy, done, illegal, fault;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    move_ctrl_seq #(
      .OPCODE_W       (5),
      .AUTO_RUN       (g == 1),
      .TIMEOUT_CYCLES (TMO)
    ) dut (
      .clock     (clk),
      .clear     (clear),
      .start     (start_a[g]),
      .ir_opcode (opc_a[g]),
      .mem_ready (mr_a[g]),
      .pco       (pco[g]),
      .mari      (mari[g]),
      .pc_inc    (pc_inc[g]),
      .mem_read  (mem_read[g]),
      .mdri      (mdri[g]),
      .mdro      (mdro[g]),
      .iri       (iri[g]),
      .gra       (gra[g]),
      .rin       (rin[g]),
      .rout      (rout[g]),
      .hio       (hio[g]),
      .loo       (loo[g]),
      .hii       (hii[g]),
      .loi       (loi[g]),
      .ipo       (ipo[g]),
      .opi       (opi[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .illegal   (illegal[g]),
      .fault     (fault[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] outv(int i);
    return {pco[i], mari[i], pc_inc[i], mem_read[i], mdri[i], mdro[i], iri[i],
            gra[i], rin[i], rout[i], hio[i], loo[i], hii[i], loi[i], ipo[i],
            opi[i], busy[i], done[i], illegal[i], fault[i]};
  endfunction

  // Reference model: an instruction is tracked by the cycle numbers of its
  // fetch start (t0), of the IR load (t2, known once memory answers) and of
  // its final done/illegal/fault cycle (endc).
  typedef enum int {K_IDLE, K_T0, K_WAIT, K_IR, K_EXEC, K_DONE, K_ILL, K_FLT} kind_e;
  int    cyc;
  bit    act   [2];
  int    t0    [2];
  int    t2    [2];
  int    endc  [2];
  kind_e ekind [2];

  function automatic kind_e kind_of(int i, int c);
    if (!act[i])                 return K_IDLE;
    if (endc[i] == c)            return ekind[i];
    if (c == t0[i])              return K_T0;
    if (t2[i] < 0 || c < t2[i])  return K_WAIT;
    if (c == t2[i])              return K_IR;
    if (c == t2[i] + 1)          return K_EXEC;
    return K_IDLE;
  endfunction

  function automatic logic [19:0] exec_bits(logic [4:0] op);
    case (op)
      5'd22:   return IPO | GRA | RIN;
      5'd23:   return GRA | ROUT | OPI;
      5'd24:   return HIO | GRA | RIN;
      5'd25:   return LOO | GRA | RIN;
      5'd26:   return GRA | ROUT | HII;
      5'd27:   return GRA | ROUT | LOI;
      default: return 20'h0;
    endcase
  endfunction

  function automatic logic [19:0] exp_vec(int i);
    case (kind_of(i, cyc))
      K_T0:    return T0V;
      K_WAIT:  return MRD | BSY | (mr_a[i] ? MDRI : 20'h0);
      K_IR:    return MDRO | IRI | BSY;
      K_EXEC:  return BSY | exec_bits(opc_a[i]);
      K_DONE:  return DON | BSY;
      K_ILL:   return ILL | BSY;
      K_FLT:   return FLT | BSY;
      default: return 20'h0;
    endcase
  endfunction

  always @(posedge clk or negedge clear) begin
    if (!clear) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        act[i]  <= 1'b0;
        t0[i]   <= -10;
        t2[i]   <= -1;
        endc[i] <= -1;
        ekind[i] <= K_IDLE;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        case (kind_of(i, cyc))
          K_IDLE: if (start_a[i]) begin
            act[i] <= 1'b1; t0[i] <= cyc + 1; t2[i] <= -1; endc[i] <= -1;
          end
          K_WAIT: begin
            if (mr_a[i]) t2[i] <= cyc + 1;
            else if (TMO_EN && (cyc - t0[i]) >= TMO) begin
              endc[i] <= cyc + 1; ekind[i] <= K_FLT;
            end
          end
          K_EXEC: begin
            endc[i]  <= cyc + 1;
            ekind[i] <= (opc_a[i] >= 5'd22 && opc_a[i] <= 5'd27) ? K_DONE : K_ILL;
          end
          K_DONE: begin
            if (i == 1) begin
              t0[i] <= cyc + 1; t2[i] <= -1; endc[i] <= -1;
            end else act[i] <= 1'b0;
          end
          K_ILL, K_FLT: act[i] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (outv(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL model inst%0d cyc%0d got=%h exp=%h", i, cyc, outv(i), exp_vec(i));
          end
        end
      end
    end
  end

  task automatic lit(string nm, logic [19:0] got, logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  logic [19:0] exp_b [1:6];
  logic [19:0] exp_c [1:9];
  logic [19:0] exp_d [1:6];
  logic [19:0] exp_e [1:10];

  initial begin
    exp_b = '{T0V, MRD|MDRI|BSY, MDRO|IRI|BSY, HIO|GRA|RIN|BSY, DON|BSY, 20'h0};
    exp_c = '{T0V, MRD|BSY, MRD|BSY, MRD|BSY, MRD|MDRI|BSY, MDRO|IRI|BSY,
              GRA|ROUT|OPI|BSY, DON|BSY, 20'h0};
    exp_d = '{T0V, MRD|MDRI|BSY, MDRO|IRI|BSY, BSY, ILL|BSY, 20'h0};
    exp_e = '{T0V, MRD|MDRI|BSY, MDRO|IRI|BSY, GRA|ROUT|LOI|BSY, DON|BSY,
              T0V, MRD|MDRI|BSY, MDRO|IRI|BSY, GRA|ROUT|HII|BSY, DON|BSY};
    for (int i = 0; i < 2; i++) begin
      start_a[i] = 1'b0;
      mr_a[i]    = 1'b0;
      opc_a[i]   = 5'd0;
    end
    clear = 1'b1;
    #1 clear = 1'b0;
    chk_en = 1'b1;
    mid();
    lit("reset_i0", outv(0), 20'h0);
    lit("reset_i1", outv(1), 20'h0);
    cyc_start();
    clear = 1'b1;

    // Reset while waiting in T1, then restart.
    cyc_start();
    start_a[0] = 1'b1; mr_a[0] = 1'b0; opc_a[0] = 5'b11000;
    cyc_start(); start_a[0] = 1'b0;
    cyc_start();
    cyc_start();
    mid();
    lit("a_in_t1", outv(0), MRD | BSY);
    clear = 1'b0;
    #1;
    lit("a_async_rst", outv(0), 20'h0);
    cyc_start();
    clear = 1'b1; start_a[0] = 1'b1; mr_a[0] = 1'b1;
    cyc_start(); start_a[0] = 1'b0;
    mid();
    lit("a_restart_t0", outv(0), T0V);
    for (int k = 0; k < 5; k++) cyc_start();

    // mfhi, memory ready immediately.
    cyc_start();
    start_a[0] = 1'b1; mr_a[0] = 1'b1; opc_a[0] = 5'b11000;
    for (int k = 1; k <= 6; k++) begin
      cyc_start();
      if (k == 1) start_a[0] = 1'b0;
      if (k == 2) start_a[0] = 1'b1;
      if (k == 3) start_a[0] = 1'b0;
      mid();
      lit($sformatf("b_mfhi_c%0d", k), outv(0), exp_b[k]);
    end

    // out with three wait cycles.
    cyc_start();
    start_a[0] = 1'b1; mr_a[0] = 1'b0; opc_a[0] = 5'b10111;
    for (int k = 1; k <= 9; k++) begin
      cyc_start();
      if (k == 1) start_a[0] = 1'b0;
      if (k == 5) mr_a[0] = 1'b1;
      mid();
      lit($sformatf("c_out_c%0d", k), outv(0), exp_c[k]);
    end

    // Unsupported opcode.
    cyc_start();
    start_a[0] = 1'b1; mr_a[0] = 1'b1; opc_a[0] = 5'b00011;
    for (int k = 1; k <= 6; k++) begin
      cyc_start();
      if (k == 1) start_a[0] = 1'b0;
      mid();
      lit($sformatf("d_ill_c%0d", k), outv(0), exp_d[k]);
    end

    // Auto-run: mtlo then mthi, then an illegal opcode stops the chain.
    cyc_start();
    start_a[1] = 1'b1; mr_a[1] = 1'b1; opc_a[1] = 5'b11011;
    for (int k = 1; k <= 10; k++) begin
      cyc_start();
      if (k == 1)  start_a[1] = 1'b0;
      if (k == 6)  opc_a[1] = 5'b11010;
      if (k == 10) opc_a[1] = 5'b00000;
      mid();
      lit($sformatf("e_auto_c%0d", k), outv(1), exp_e[k]);
    end
    for (int k = 0; k < 6; k++) cyc_start();
    mid();
    lit("e_auto_stopped", outv(1), 20'h0);

    // Memory never ready.
    cyc_start();
    start_a[0] = 1'b1; mr_a[0] = 1'b0; opc_a[0] = 5'b11001;
    for (int k = 1; k <= 101; k++) begin
      cyc_start();
      if (k == 1) start_a[0] = 1'b0;
      mid();
`ifdef MOVE_CTRL_TIMEOUT_EN
      if (k == 17) lit("f_last_t1", outv(0), MRD | BSY);
      if (k == 18) lit("f_fault", outv(0), FLT | BSY);
      if (k == 19) lit("f_idle", outv(0), 20'h0);
`else
      if (k == 101) lit("f_still_t1", outv(0), MRD | BSY);
`endif
    end

    cyc_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
